serial_tx_arbiter: RTL

- Shares the single AVR serial transmit path between two requesters: the MIDI byte detector and a status-byte source.
- MIDI bytes arrive as unsolicited one-cycle pulses with no backpressure, so they are buffered in a small FIFO.
- The status source uses a valid/ready handshake.
- The block sits between the sources and the avr_interface transmit port, round-robin arbitrates between them, and sequences each byte onto the UART while honouring tx_busy and tx_block.

---
 rtl/serial_tx_arb_pkg.sv | 29 ++
 rtl/serial_tx_arbiter_if.sv | 39 +++
 rtl/midi_tx_fifo.sv | 73 +++++++
 rtl/serial_tx_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/serial_tx_arb_pkg.sv
// serial_tx_arb_pkg
// Shared types and constants for the serial transmit arbiter.
//   state_e : transmit sequencer states
//   src_e   : arbitration sources
//   DROP_CNT_W / SENT_CNT_W : statistics counter widths
//   sat_inc : saturating increment for the drop counter

package serial_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GUARD,
        WAIT
    } state_e;

    typedef enum logic {
        SRC_MIDI,
        SRC_STAT
    } src_e;

    localparam int unsigned DROP_CNT_W = 8;
    localparam int unsigned SENT_CNT_W = 16;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/serial_tx_arbiter_if.sv
// serial_tx_arbiter_if
// Bundles the source, UART and status signals of the serial transmit arbiter.
//   master : environment side (MIDI detector, status source, UART, host)
//   slave  : arbiter side
// Parameter FIFO_DEPTH sizes fifo_level and must match the arbiter instance.

interface serial_tx_arbiter_if
    import serial_tx_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]            midi_byte;
    logic                  midi_byte_ready;
    logic [7:0]            stat_data;
    logic                  stat_valid;
    logic                  stat_ready;
    logic [7:0]            tx_data;
    logic                  new_tx_data;
    logic                  tx_busy;
    logic                  tx_block;
    logic                  clear_ovf;
    logic [LEVEL_W-1:0]    fifo_level;
    logic                  overflow;
    logic [DROP_CNT_W-1:0] drop_count;
    logic [SENT_CNT_W-1:0] sent_count;

    modport master (
        output midi_byte, midi_byte_ready, stat_data, stat_valid, tx_busy, tx_block, clear_ovf,
        input  stat_ready, tx_data, new_tx_data, fifo_level, overflow, drop_count, sent_count
    );

    modport slave (
        input  midi_byte, midi_byte_ready, stat_data, stat_valid, tx_busy, tx_block, clear_ovf,
        output stat_ready, tx_data, new_tx_data, fifo_level, overflow, drop_count, sent_count
    );

endinterface

// File: rtl/midi_tx_fifo.sv
// midi_tx_fifo
// Synchronous first-word-fall-through byte FIFO for MIDI bytes.
//   clk, rst     : clock, asynchronous active-high reset
//   i_push       : write request; ignored when full unless a pop happens in the same cycle
//   i_push_data  : byte to write
//   i_pop        : read request; ignored when empty
//   o_pop_data   : head of the FIFO (valid whenever o_empty is low)
//   o_empty      : no entries
//   o_full       : FIFO_DEPTH entries
//   o_level      : current occupancy, 0..FIFO_DEPTH

module midi_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [7:0]                    i_push_data,
    input  logic                          i_pop,
    output logic [7:0]                    o_pop_data,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_do_push;
    logic          w_do_pop;

    always_comb begin
        o_empty   = (r_level == '0);
        o_full    = (r_level == LW'(FIFO_DEPTH));
        w_do_pop  = i_pop && !o_empty;
        // A pop frees the slot this cycle, so a push into a full FIFO is still accepted.
        w_do_push = i_push && (!o_full || w_do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_level    = r_level;

endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
// Shares the AVR serial transmit path between the MIDI byte detector (buffered in a FIFO,
// no backpressure) and a valid/ready status source. Round-robin arbitration, one byte in
// flight, sequenced as IDLE -> SEND -> GUARD -> WAIT around the UART busy/block signals.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : serial_tx_arbiter_if slave modport (sources, UART port, flags, counters)
// Build option: define SERIAL_TX_ARB_STATS_EN to implement drop_count and sent_count;
// otherwise both outputs are tied to zero.

module serial_tx_arbiter
    import serial_tx_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_tx_arbiter_if.slave   bus
);
    localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [7:0]         w_fifo_data;
    logic [LEVEL_W-1:0] w_fifo_level;

    logic               w_req_midi;
    logic               w_req_stat;
    logic               w_grant;
    src_e               w_sel;
    logic               w_pop;
    logic               w_drop;

    state_e             r_state;
    src_e               r_last_grant;
    logic [7:0]         r_tx_data;
    logic               r_new_tx_data;
    logic               r_overflow;

    midi_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (bus.midi_byte_ready),
        .i_push_data (bus.midi_byte),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_data),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full),
        .o_level     (w_fifo_level)
    );

    always_comb begin
        w_req_midi = !w_fifo_empty;
        w_req_stat = bus.stat_valid;
        w_grant    = (r_state == IDLE) && (w_req_midi || w_req_stat)
                     && !bus.tx_busy && !bus.tx_block;
        // On a tie the source not served last wins; a sole requester always wins.
        if (w_req_midi && w_req_stat) begin
            w_sel = (r_last_grant == SRC_STAT) ? SRC_MIDI : SRC_STAT;
        end else if (w_req_midi) begin
            w_sel = SRC_MIDI;
        end else begin
            w_sel = SRC_STAT;
        end
        w_pop  = w_grant && (w_sel == SRC_MIDI);
        w_drop = bus.midi_byte_ready && w_fifo_full && !w_pop;
    end

    // Gated by rst so a pending status byte is never acknowledged while held in reset.
    assign bus.stat_ready = w_grant && (w_sel == SRC_STAT) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_grant  <= SRC_STAT;
            r_tx_data     <= '0;
            r_new_tx_data <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_tx_data     <= (w_sel == SRC_MIDI) ? w_fifo_data : bus.stat_data;
                        r_last_grant  <= w_sel;
                        r_new_tx_data <= 1'b1;
                        r_state       <= SEND;
                    end
                end
                SEND: begin
                    r_new_tx_data <= 1'b0;
                    r_state       <= GUARD;
                end
                // The UART raises tx_busy one cycle after the launch; skip that cycle.
                GUARD: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (!bus.tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // A drop in the same cycle as clear_ovf keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.tx_data     = r_tx_data;
    assign bus.new_tx_data = r_new_tx_data;
    assign bus.fifo_level  = w_fifo_level;
    assign bus.overflow    = r_overflow;

`ifdef SERIAL_TX_ARB_STATS_EN
    logic [DROP_CNT_W-1:0] r_drop_count;
    logic [SENT_CNT_W-1:0] r_sent_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_count <= '0;
            r_sent_count <= '0;
        end else begin
            if (w_drop) begin
                r_drop_count <= sat_inc(r_drop_count);
            end
            if (w_grant) begin
                r_sent_count <= r_sent_count + 1'b1;
            end
        end
    end

    assign bus.drop_count = r_drop_count;
    assign bus.sent_count = r_sent_count;
`else
    assign bus.drop_count = '0;
    assign bus.sent_count = '0;
`endif

endmodule
